// File: rtl/adxl_spi_if.sv
// Host-side and pin-side signals of the ADXL355-style SPI master, grouped so
// the master and the host/sensor side see complementary directions.
interface adxl_spi_if;
  logic       cs_n_in;
  logic       miso;
  logic       wr_rd;
  logic [7:0] spi_data_master;
  logic [6:0] spi_addr_master;
  logic       data_out_vld;
  logic [7:0] data_out;
  logic       cs_n;
  logic       sclk;
  logic       mosi;

  modport master (
    input  cs_n_in, miso, wr_rd, spi_data_master, spi_addr_master,
    output data_out_vld, data_out, cs_n, sclk, mosi
  );

  modport slave (
    output cs_n_in, miso, wr_rd, spi_data_master, spi_addr_master,
    input  data_out_vld, data_out, cs_n, sclk, mosi
  );
endinterface

// File: rtl/adxl_spi_master.sv
// SPI mode-0 master for an ADXL355-style register port. While the host holds
// cs_n_in low it sends {addr, R/W} and then streams data bytes, so single and
// burst accesses share one mechanism. Read bytes come back on data_out with a
// one-clock data_out_vld pulse.
module adxl_spi_master #(
  parameter int CLK_DIV = 40
) (
  input logic        clk,
  input logic        rst_n,
  adxl_spi_if.master bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_C = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLK_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    byte_idx, byte_idx_nx;
  logic [7:0]    tx, tx_nx;
  logic [7:0]    rx, rx_nx;
  logic          rw, rw_nx;
  logic          cs_r, cs_nx;
  logic          sclk_r, sclk_nx;
  logic          mosi_r, mosi_nx;
  logic [7:0]    dout, dout_nx;
  logic          dvld, dvld_nx;
  logic          wrap;

  // Byte counter stops at 255 on very long bursts instead of rolling over.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign wrap = (cnt == LAST_C);

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_idx_nx  = bit_idx;
    byte_idx_nx = byte_idx;
    tx_nx       = tx;
    rx_nx       = rx;
    rw_nx       = rw;
    cs_nx       = cs_r;
    sclk_nx     = sclk_r;
    mosi_nx     = mosi_r;
    dout_nx     = dout;
    dvld_nx     = 1'b0;
    case (state)
      IDLE: begin
        cs_nx   = 1'b1;
        sclk_nx = 1'b0;
        mosi_nx = 1'b0;
        if (!bus.cs_n_in) begin
          state_nx    = SHIFT;
          cs_nx       = 1'b0;
          tx_nx       = {bus.spi_addr_master, bus.wr_rd};
          rw_nx       = bus.wr_rd;
          mosi_nx     = bus.spi_addr_master[6];
          cnt_nx      = '0;
          bit_idx_nx  = 3'd0;
          byte_idx_nx = 8'd0;
          rx_nx       = 8'd0;
        end
      end
      SHIFT: begin
        // A completed read data byte is delivered even if the frame closes on
        // this very edge; the command byte never produces a pulse.
        if (wrap && bit_idx == 3'd7 && rw && byte_idx != 8'd0) begin
          dout_nx = rx;
          dvld_nx = 1'b1;
        end
        if (bus.cs_n_in) begin
          state_nx = IDLE;
          cs_nx    = 1'b1;
          sclk_nx  = 1'b0;
          mosi_nx  = 1'b0;
        end else begin
          cnt_nx  = wrap ? '0 : cnt + CW'(1);
          sclk_nx = (cnt_nx >= HALF_C);
          // The edge that raises sclk is the edge that samples miso.
          if (cnt_nx == HALF_C)
            rx_nx = {rx[6:0], bus.miso};
          if (wrap) begin
            if (bit_idx == 3'd7) begin
              bit_idx_nx  = 3'd0;
              byte_idx_nx = sat_inc(byte_idx);
              tx_nx       = rw ? 8'd0 : bus.spi_data_master;
              mosi_nx     = rw ? 1'b0 : bus.spi_data_master[7];
            end else begin
              bit_idx_nx = bit_idx + 3'd1;
              tx_nx      = {tx[6:0], tx[7]};
              mosi_nx    = tx[6];
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 8'd0;
      tx       <= 8'd0;
      rx       <= 8'd0;
      rw       <= 1'b0;
      cs_r     <= 1'b1;
      sclk_r   <= 1'b0;
      mosi_r   <= 1'b0;
      dout     <= 8'd0;
      dvld     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_idx_nx;
      byte_idx <= byte_idx_nx;
      tx       <= tx_nx;
      rx       <= rx_nx;
      rw       <= rw_nx;
      cs_r     <= cs_nx;
      sclk_r   <= sclk_nx;
      mosi_r   <= mosi_nx;
      dout     <= dout_nx;
      dvld     <= dvld_nx;
    end
  end

  assign bus.cs_n         = cs_r;
  assign bus.sclk         = sclk_r;
  assign bus.mosi         = mosi_r;
  assign bus.data_out     = dout;
  assign bus.data_out_vld = dvld;

endmodule

// File: tb/tb_adxl_spi_master.sv
// Bench for adxl_spi_master: directed frames from the test plan plus random
// frames, scored against a frame-level model of the SPI transaction.
module tb_adxl_spi_master;

  localparam int DIV      = 40;
  localparam int BYTE_CLK = 8 * DIV;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adxl_spi_if bus();

  adxl_spi_master #(.CLK_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passes = 0;
  int total  = 0;

  logic [7:0] wdat [0:7];
  logic [7:0] sdat [0:7];
  logic [7:0] exp_dout = 8'd0;

  logic       mosi_bits [$];
  int         rise_cyc  [$];
  logic [7:0] vld_data  [$];
  int         vld_double = 0;
  int         cyc        = 0;
  int         sidx       = 0;
  logic       sclk_prev  = 1'b0;
  logic       vld_prev   = 1'b0;

  // Pin monitor and mode-0 slave: records each sclk rise and read pulse,
  // and shifts the slave stream out on sclk falling edges.
  always @(negedge clk) begin
    logic [7:0] sb;
    cyc++;
    if (bus.sclk && !sclk_prev && !bus.cs_n) begin
      mosi_bits.push_back(bus.mosi);
      rise_cyc.push_back(cyc);
    end
    if (bus.data_out_vld) begin
      vld_data.push_back(bus.data_out);
      if (vld_prev) vld_double++;
    end
    vld_prev = bus.data_out_vld;
    if (bus.cs_n) sidx = 0;
    else if (!bus.sclk && sclk_prev) sidx++;
    sb = sdat[(sidx / 8) % 8];
    bus.miso = sb[7 - (sidx % 8)];
    sclk_prev = bus.sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Runs one frame with cs_n_in low for len clocks, then scores it.
  task automatic run_frame(input logic [6:0] addr, input logic rw, input int n, input int len);
    int nfull, rises, nv, bad;
    logic [7:0] expb, capb;
    mosi_bits.delete();
    rise_cyc.delete();
    vld_data.delete();
    vld_double = 0;
    bus.spi_addr_master = addr;
    bus.wr_rd           = rw;
    bus.spi_data_master = 8'($urandom);
    bus.cs_n_in         = 1'b0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.wr_rd           = 1'($urandom);
        bus.spi_addr_master = 7'($urandom);
      end
      for (int j = 0; j < n; j++) begin
        if (c - 1 == BYTE_CLK * (j + 1) - 3) bus.spi_data_master = wdat[j];
        if (c - 1 == BYTE_CLK * (j + 1) + 2) bus.spi_data_master = 8'($urandom);
      end
      if (c == len) bus.cs_n_in = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("close_cs_n", bus.cs_n, 1);
    chk("close_sclk", bus.sclk, 0);
    chk("close_mosi", bus.mosi, 0);

    nfull = len / BYTE_CLK;
    rises = (len + DIV / 2 - 1) / DIV;
    chk("sclk_rises", mosi_bits.size(), rises);
    bad = 0;
    for (int i = 1; i < rise_cyc.size(); i++)
      if (rise_cyc[i] - rise_cyc[i-1] != DIV) bad++;
    chk("sclk_period_errs", bad, 0);
    for (int b = 0; b < nfull; b++) begin
      expb = (b == 0) ? {addr, rw} : (rw ? 8'd0 : wdat[b-1]);
      capb = 8'd0;
      for (int k = 0; k < 8; k++)
        if (8 * b + k < mosi_bits.size()) capb[7-k] = mosi_bits[8*b+k];
      chk("mosi_byte", capb, expb);
    end
    if (rises > 8 * nfull) begin
      bad = 0;
      for (int i = 8 * nfull; i < rises && i < mosi_bits.size(); i++) begin
        expb = (nfull == 0) ? {addr, rw} : (rw ? 8'd0 : wdat[nfull-1]);
        if (mosi_bits[i] !== expb[7 - (i % 8)]) bad++;
      end
      chk("mosi_partial_errs", bad, 0);
    end
    nv = (rw && nfull > 1) ? nfull - 1 : 0;
    chk("vld_count", vld_data.size(), nv);
    for (int k = 0; k < nv && k < vld_data.size(); k++)
      chk("vld_data", vld_data[k], sdat[k+1]);
    if (nv > 0) exp_dout = sdat[nv];
    chk("data_out_hold", bus.data_out, exp_dout);
    chk("vld_width", vld_double, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      wdat[i] = 8'($urandom);
      sdat[i] = 8'($urandom);
    end
  endtask

  initial begin
    int n, len;
    logic rw;
    rst_n               = 1'b0;
    bus.cs_n_in         = 1'b1;
    bus.wr_rd           = 1'b0;
    bus.spi_addr_master = 7'd0;
    bus.spi_data_master = 8'd0;
    fill_random();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_vld", bus.data_out_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Single write 0x7F / 0xFF
    wdat[0] = 8'hFF;
    run_frame(7'h7F, 1'b0, 1, 2 * BYTE_CLK);
    // Single read 0x7F, slave returns 0xEF
    sdat[1] = 8'hEF;
    run_frame(7'h7F, 1'b1, 1, 2 * BYTE_CLK);
    // Burst write to 0x02
    wdat[0] = 8'h01; wdat[1] = 8'h01; wdat[2] = 8'h02;
    wdat[3] = 8'h03; wdat[4] = 8'h04; wdat[5] = 8'h05;
    run_frame(7'h02, 1'b0, 6, 7 * BYTE_CLK);
    // Burst read from 0x02, slave drives 0xEF
    for (int i = 0; i < 8; i++) sdat[i] = 8'hEF;
    run_frame(7'h02, 1'b1, 6, 7 * BYTE_CLK);
    // Early close of a read after 500 clocks
    fill_random();
    run_frame(7'($urandom), 1'b1, 1, 500);

    // Reset during bit 5 of the first data byte of a read
    fill_random();
    bus.wr_rd           = 1'b1;
    bus.spi_addr_master = 7'($urandom);
    bus.cs_n_in         = 1'b0;
    repeat (BYTE_CLK + 5 * DIV + 10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", bus.cs_n, 1);
    chk("midrst_sclk", bus.sclk, 0);
    chk("midrst_mosi", bus.mosi, 0);
    chk("midrst_data_out", bus.data_out, 0);
    chk("midrst_vld", bus.data_out_vld, 0);
    bus.cs_n_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_dout = 8'd0;
    @(negedge clk);
    #1;
    fill_random();
    run_frame(7'($urandom), 1'b1, 2, 3 * BYTE_CLK);

    // Random frames, some closed mid-byte, some back-to-back
    for (int f = 0; f < 8; f++) begin
      fill_random();
      n   = $urandom_range(1, 6);
      rw  = 1'($urandom);
      len = ($urandom_range(0, 1) == 1) ? BYTE_CLK * (n + 1)
                                        : $urandom_range(21, BYTE_CLK * (n + 1));
      run_frame(7'($urandom), rw, n, len);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/adxl_spi_master.md
Name: adxl_spi_master

Overview:
- Single-clock SPI master for the ADXL355-style register interface.
- Runs SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- While the host holds cs_n_in low, it sends a command byte {addr[6:0], R/W} and then streams data bytes for as long as the frame stays open, so single and burst accesses use the same mechanism.
- Sits between the register-access sequencer and the sensor pins.

Parameters:
- CLK_DIV, 40: clk cycles per SCLK period. Must be even and ≥4. At 50 MHz this gives 1.25 MHz SCLK, 40 clk per bit, 320 clk per byte.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- cs_n_in  input  1  host frame request: low = frame open, high = frame closed
- miso  input  1  serial data from slave
- wr_rd  input  1  1 = read, 0 = write; latched at frame start
- spi_data_master  input  8  write data; sampled at the start of each data byte
- spi_addr_master  input  7  register address; latched at frame start
- data_out_vld  output  1  one-clk pulse when data_out holds a new read byte
- data_out  output  8  last received read byte
- cs_n  output  1  SPI chip select, active low
- sclk  output  1  SPI clock, idle low
- mosi  output  1  serial data to slave

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: cs_n=1, sclk=0, mosi=0, data_out=0x00, data_out_vld=0. All counters and shift registers cleared.
- Reset asserted mid-frame aborts the frame immediately.
- States: IDLE, SHIFT.

IDLE:
- cs_n=1, sclk=0, mosi=0.
- On a clk edge that samples cs_n_in=0, go to SHIFT. On the same edge:
  - cs_n becomes 0 (cs_n is cs_n_in registered, 1-clk latency).
  - Latch tx byte = {spi_addr_master, wr_rd} and latched rw = wr_rd.
  - Drive mosi = bit 7 of the tx byte.
  - Clear phase counter cnt (0..CLK_DIV-1), bit index (0..7) and byte index.

SHIFT, per bit:
- sclk = 0 while cnt < CLK_DIV/2, and 1 otherwise.
- The SCLK rising edge occurs at cnt = CLK_DIV/2. miso is sampled into the rx shift register on that edge.
- When cnt wraps from CLK_DIV-1 to 0, the bit ends. The next tx bit is placed on mosi in the same cycle sclk returns low.
- After bit 7 of a byte, bit index returns to 0 and byte index increments (saturate at 255).

Data bytes (byte index ≥ 1):
- Write frame (rw=0): load spi_data_master at the start of each data byte and shift it out MSB first.
- Read frame (rw=1): mosi = 0. At the end of each data byte (the wrap following bit 7):
  - data_out ← received byte;
  - data_out_vld = 1 for exactly one clk.
- The command byte never produces data_out_vld. Write frames never produce data_out_vld.

Frame end:
- On a clk edge that samples cs_n_in=1 in SHIFT: next cycle cs_n=1, sclk=0, mosi=0, state IDLE.
- If the close coincides with a byte-end wrap, the vld pulse for that byte is still issued.
- A partial byte is discarded with no vld.

Back-to-back frames:
- cs_n_in may go low again the cycle after it goes high. cs_n stays high for at least 1 clk between frames.
- wr_rd, spi_addr_master and spi_data_master changing mid-byte have no effect until their next sample point.

Test Plan:
- Single write: addr 0x7F, data 0xFF, wr_rd=0, cs_n_in low for 640 clk.
  -> 16 SCLK pulses, period 40 clk; mosi = 0xFE then 0xFF; no data_out_vld; cs_n returns to 1.
- Single read: addr 0x7F, wr_rd=1, slave returns 0xEF, cs_n_in low 640 clk.
  -> mosi command 0xFF; exactly one data_out_vld pulse with data_out=0xEF at the end of clk ~640.
- Burst write: addr 0x02, spi_data_master = 0x01, then 0x01..0x05 changed every 320 clk, frame 6 data bytes (2240 clk).
  -> mosi bytes 0x04, 0x01, 0x01, 0x02, 0x03, 0x04, 0x05; 56 SCLK pulses.
- Burst read: addr 0x02, wr_rd=1, frame 320×7 clk, slave drives 0xEF.
  -> command 0x05; 6 data_out_vld pulses, 320 clk apart, each data_out=0xEF.
- Early close: cs_n_in high after 500 clk of a read.
  -> cs_n=1 and sclk=0 next cycle; no vld; data_out unchanged.
- Reset mid-frame: rst_n low during bit 5 of the data byte.
  -> all outputs immediately at reset values; after release the next frame starts cleanly.
